// File: rtl/video_downscale_capture_pkg.sv
// Shared constants and types for the 28x28 downscale capture path.
// The display controller reads the same buffer geometry from here.
package video_downscale_capture_pkg;

    localparam int H_RES        = 1920;
    localparam int V_RES        = 1080;
    localparam int D_DIM        = 28;
    localparam int D_SIZE       = D_DIM * D_DIM;
    localparam int BLK_LOG2     = 5;
    localparam int CROP_H_START = 512;
    localparam int CROP_V_START = 92;

    localparam int PIX_W  = 24;
    localparam int GRAY_W = 8;
    localparam int ADDR_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_SOF,
        ST_CAPTURE,
        ST_DONE
    } cap_state_t;

endpackage

// File: rtl/video_downscale_capture_if.sv
// Pixel stream in, capture control, and downscale buffer write port.
interface video_downscale_capture_if;
    import video_downscale_capture_pkg::*;

    logic              data_valid_i;
    logic [PIX_W-1:0]  data_i;
    logic              capture_req_i;
    logic              busy_o;
    logic              done_o;
    logic              wr_en_o;
    logic [ADDR_W-1:0] wr_addr_o;
    logic [GRAY_W-1:0] wr_data_o;

    // Video source / controller side.
    modport master (
        output data_valid_i, data_i, capture_req_i,
        input  busy_o, done_o, wr_en_o, wr_addr_o, wr_data_o
    );

    // Capture block side.
    modport slave (
        input  data_valid_i, data_i, capture_req_i,
        output busy_o, done_o, wr_en_o, wr_addr_o, wr_data_o
    );

endinterface

// File: rtl/video_downscale_capture_gray.sv
// Registered RGB to 8-bit grayscale: (R + 2G + B) >> 2, optionally inverted.
module rgb_to_gray #(
    parameter bit INVERT = 1'b0
) (
    input  logic                                           clk,
    input  logic                                           reset_n,
    input  logic                                           en,
    input  logic [video_downscale_capture_pkg::PIX_W-1:0]  rgb,
    output logic [video_downscale_capture_pkg::GRAY_W-1:0] gray
);
    import video_downscale_capture_pkg::*;

    logic [GRAY_W+1:0] sum;
    logic [GRAY_W-1:0] gray_nx;

    assign sum     = (GRAY_W+2)'(rgb[23:16]) + {1'b0, rgb[15:8], 1'b0} + (GRAY_W+2)'(rgb[7:0]);
    assign gray_nx = INVERT ? ~sum[GRAY_W+1:2] : sum[GRAY_W+1:2];

    // Load the converted pixel only when a pixel is accepted.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            gray <= '0;
        end else if (en) begin
            gray <= gray_nx;
        end
    end

endmodule

// File: rtl/video_downscale_capture.sv
// Crops a centred window of the pixel stream, averages each block to one
// gray pixel and writes the D_DIM x D_DIM image once per capture request.
module video_downscale_capture #(
    parameter int H_RES        = video_downscale_capture_pkg::H_RES,
    parameter int V_RES        = video_downscale_capture_pkg::V_RES,
    parameter int D_DIM        = video_downscale_capture_pkg::D_DIM,
    parameter int BLK_LOG2     = video_downscale_capture_pkg::BLK_LOG2,
    parameter int CROP_H_START = video_downscale_capture_pkg::CROP_H_START,
    parameter int CROP_V_START = video_downscale_capture_pkg::CROP_V_START,
    parameter bit INVERT       = 1'b0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    video_downscale_capture_if.slave  bus
);
    import video_downscale_capture_pkg::*;

    localparam int CROP_DIM = D_DIM << BLK_LOG2;
    localparam int OUT_SIZE = D_DIM * D_DIM;
    localparam int H_W      = $clog2(H_RES);
    localparam int V_W      = $clog2(V_RES);
    localparam int BX_W     = (D_DIM > 1) ? $clog2(D_DIM) : 1;
    localparam int ACC_W    = GRAY_W + 2 * BLK_LOG2;

    localparam logic [H_W-1:0]      H_LAST       = H_W'(H_RES - 1);
    localparam logic [V_W-1:0]      V_LAST       = V_W'(V_RES - 1);
    localparam logic [H_W-1:0]      H_CROP_FIRST = H_W'(CROP_H_START);
    localparam logic [H_W-1:0]      H_CROP_LAST  = H_W'(CROP_H_START + CROP_DIM - 1);
    localparam logic [V_W-1:0]      V_CROP_FIRST = V_W'(CROP_V_START);
    localparam logic [V_W-1:0]      V_CROP_LAST  = V_W'(CROP_V_START + CROP_DIM - 1);
    localparam logic [BLK_LOG2-1:0] P_LAST       = '1;
    localparam logic [BX_W-1:0]     B_LAST       = BX_W'(D_DIM - 1);
    localparam logic [ADDR_W-1:0]   ADDR_LAST    = ADDR_W'(OUT_SIZE - 1);

    cap_state_t state, state_nx;

    logic [H_W-1:0]      h;
    logic [V_W-1:0]      v;
    logic [BLK_LOG2-1:0] px, py;
    logic [BX_W-1:0]     bx, by;
    logic                line_end, h_in, v_in, sof, take;

    logic                s1_valid, s1_first, s1_last;
    logic [BX_W-1:0]     s1_bx;
    logic [GRAY_W-1:0]   s1_gray;

    logic [ACC_W-1:0]    acc [D_DIM];
    logic [ACC_W-1:0]    blk_sum;
    logic                wr_fire;
    logic [ADDR_W-1:0]   addr_cnt;

    logic                wr_en_q, busy_q, done_q, busy_d, done_d;
    logic [ADDR_W-1:0]   wr_addr_q;
    logic [GRAY_W-1:0]   wr_data_q;

    assign line_end = (h == H_LAST);
    assign h_in     = (h >= H_CROP_FIRST) && (h <= H_CROP_LAST);
    assign v_in     = (v >= V_CROP_FIRST) && (v <= V_CROP_LAST);
    assign sof      = bus.data_valid_i && (h == '0) && (v == '0);

    // A pixel enters the pipeline only while capturing (the SOF pixel itself included).
    assign take = bus.data_valid_i && h_in && v_in &&
                  ((state == ST_CAPTURE) || ((state == ST_WAIT_SOF) && sof));

    // Raster position of the pixel currently on data_i; moves only on valid pixels.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            h <= '0;
            v <= '0;
        end else if (bus.data_valid_i) begin
            if (line_end) begin
                h <= '0;
                v <= (v == V_LAST) ? '0 : v + 1'b1;
            end else begin
                h <= h + 1'b1;
            end
        end
    end

    // In-crop block coordinates, stepped alongside h/v so no divider is needed.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            px <= '0;
            bx <= '0;
            py <= '0;
            by <= '0;
        end else if (bus.data_valid_i) begin
            if (line_end) begin
                px <= '0;
                bx <= '0;
                if (v == V_LAST) begin
                    py <= '0;
                    by <= '0;
                end else if (v_in) begin
                    py <= py + 1'b1;
                    if (py == P_LAST) by <= (by == B_LAST) ? '0 : by + 1'b1;
                end
            end else if (h_in) begin
                px <= px + 1'b1;
                if (px == P_LAST) bx <= (bx == B_LAST) ? '0 : bx + 1'b1;
            end
        end
    end

    rgb_to_gray #(.INVERT(INVERT)) u_gray (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (take),
        .rgb     (bus.data_i),
        .gray    (s1_gray)
    );

    // Stage 1: block-position flags travel with the registered gray value.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_bx    <= '0;
        end else begin
            s1_valid <= take;
            if (take) begin
                s1_first <= (px == '0) && (py == '0);
                s1_last  <= (px == P_LAST) && (py == P_LAST);
                s1_bx    <= bx;
            end
        end
    end

    assign blk_sum = acc[s1_bx] + ACC_W'(s1_gray);
    assign wr_fire = s1_valid && s1_last;

    // Stage 2: one running sum per block column, restarted at each block's first pixel.
    always_ff @(posedge clk) begin
        // NOTE: the accumulator array is cleared on reset; it is small and a known start keeps write data deterministic.
        if (!reset_n) begin
            for (int i = 0; i < D_DIM; i++) acc[i] <= '0;
        end else if (s1_valid) begin
            acc[s1_bx] <= s1_first ? ACC_W'(s1_gray) : blk_sum;
        end
    end

    // Buffer write: block average plus running raster address.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            addr_cnt  <= '0;
        end else begin
            wr_en_q <= wr_fire;
            if (wr_fire) begin
                wr_addr_q <= addr_cnt;
                wr_data_q <= blk_sum[ACC_W-1:2*BLK_LOG2];
                addr_cnt  <= (addr_cnt == ADDR_LAST) ? '0 : addr_cnt + 1'b1;
            end else if (state == ST_IDLE) begin
                addr_cnt <= '0;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nx;
    end

    // FSM next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nx unassigned and infers a latch.
        state_nx = state;
        case (state)
            ST_IDLE:     if (bus.capture_req_i) state_nx = ST_WAIT_SOF;
            ST_WAIT_SOF: if (sof) state_nx = ST_CAPTURE;
            ST_CAPTURE:  if (wr_fire && (addr_cnt == ADDR_LAST)) state_nx = ST_DONE;
            ST_DONE:     state_nx = ST_IDLE;
            default:     state_nx = ST_IDLE;
        endcase
    end

    // FSM output decode of the current state.
    always_comb begin
        busy_d = (state == ST_WAIT_SOF) || (state == ST_CAPTURE);
        done_d = (state == ST_DONE);
    end

    // Registered status outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign bus.busy_o    = busy_q;
    assign bus.done_o    = done_q;
    assign bus.wr_en_o   = wr_en_q;
    assign bus.wr_addr_o = wr_addr_q;
    assign bus.wr_data_o = wr_data_q;

endmodule
